ysyx_25030085_lsu: RTL and testbench

YSYX_25030085_LSU -- requirements
Module: ysyx_25030085_LSU

---
 rtl/ysyx_25030085_lsu.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_25030085_lsu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: accepts one core memory request at a time, checks alignment and legality,
// drives a single-beat bus with byte lanes, and returns the extracted/extended load result.
module ysyx_25030085_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        MemOp,
    input  logic [AW-1:0]     addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              out_valid,
    output logic [XLEN-1:0]   ReadData,
    output logic              err,
    output logic              bus_req,
    output logic              bus_wen,
    output logic [AW-1:0]     bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wmask,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            is_load_q, is_load_d;
    logic [2:0]      memop_q, memop_d;
    logic [OW-1:0]   off_q, off_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_wen_q, bus_wen_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]   bus_wmask_q, bus_wmask_d;

    logic            accept_s;
    logic            req_err_s;
    logic [OW-1:0]   in_off_s;

    // MemOp[2] marks unsigned loads; stores have no unsigned forms and 64-bit ops need XLEN=64.
    function automatic logic access_err(input logic load, input logic [2:0] op,
                                        input logic [OW-1:0] off);
        logic bad;
        case (op[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off[1:0] != 2'b00);
            2'b11:   bad = (off != '0) || (XLEN == 32);
            default: bad = 1'b1;
        endcase
        if (op[2]) begin
            if (!load || (op[1:0] == 2'b11)) begin
                bad = 1'b1;
            end else if ((op[1:0] == 2'b10) && (XLEN == 32)) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    function automatic logic [NB-1:0] base_mask(input logic [1:0] size);
        logic [NB-1:0] m;
        m = '0;
        case (size)
            2'b00:   m[0]   = 1'b1;
            2'b01:   m[1:0] = 2'b11;
            2'b10:   m[3:0] = 4'hF;
            default: m      = '1;
        endcase
        return m;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                    input logic [2:0] op,
                                                    input logic [OW-1:0] off);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = raw >> {off, 3'b000};
        case (op)
            3'b000:  res = XLEN'($signed(sh[7:0]));
            3'b001:  res = XLEN'($signed(sh[15:0]));
            3'b010:  res = XLEN'($signed(sh[31:0]));
            3'b011:  res = sh;
            3'b100:  res = XLEN'(sh[7:0]);
            3'b101:  res = XLEN'(sh[15:0]);
            3'b110:  res = XLEN'(sh[31:0]);
            default: res = '0;
        endcase
        return res;
    endfunction

    assign in_off_s  = addr[OW-1:0];
    assign accept_s  = (state_q == S_IDLE) && in_valid && (MemRead || MemWrite);
    assign req_err_s = access_err(MemRead, MemOp, in_off_s);

    // Next-state and next-output computation for the request/bus/response sequence.
    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        memop_d     = memop_q;
        off_d       = off_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_wen_d   = bus_wen_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    is_load_d = MemRead;
                    memop_d   = MemOp;
                    off_d     = in_off_s;
                    if (req_err_s) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d    = S_REQ;
                        bus_req_d  = 1'b1;
                        bus_wen_d  = !MemRead;
                        bus_addr_d = {addr[AW-1:OW], {OW{1'b0}}};
                        if (MemRead) begin
                            bus_wdata_d = '0;
                            bus_wmask_d = '0;
                        end else begin
                            bus_wdata_d = wdata << {in_off_s, 3'b000};
                            bus_wmask_d = base_mask(MemOp[1:0]) << in_off_s;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    bus_wen_d = 1'b0;
                    if (is_load_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b0;
                        rdata_d = '0;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    rdata_d = load_extend(bus_rdata, memop_q, off_q);
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_RESP);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            memop_q     <= 3'b000;
            off_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_wen_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            memop_q     <= memop_d;
            off_q       <= off_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_wen_q   <= bus_wen_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign ReadData  = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_wen   = bus_wen_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Randomized bench for the LSU: a transaction-level timing/data model predicts every cycle's
// outputs; directed cases pin the model with hand-computed values. A 64-bit instance covers ld/lw/lwu.
module tb_ysyx_25030085_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  MemOp = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0, bus_rdata = 32'h0;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic        in_ready, out_valid, err, bus_req, bus_wen;
    logic [31:0] ReadData, bus_addr, bus_wdata;
    logic [3:0]  bus_wmask;

    logic        in_valid64 = 1'b0, MemRead64 = 1'b0, MemWrite64 = 1'b0;
    logic [2:0]  MemOp64 = 3'b000;
    logic [31:0] addr64 = 32'h0;
    logic [63:0] wdata64 = 64'h0, bus_rdata64 = 64'h0;
    logic        bus_gnt64 = 1'b0, bus_rvalid64 = 1'b0;
    logic        in_ready64, out_valid64, err64, bus_req64, bus_wen64;
    logic [63:0] ReadData64, bus_wdata64;
    logic [31:0] bus_addr64;
    logic [7:0]  bus_wmask64;

    ysyx_25030085_lsu #(.XLEN(32), .AW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemOp(MemOp), .addr(addr), .wdata(wdata),
        .out_valid(out_valid), .ReadData(ReadData), .err(err),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    ysyx_25030085_lsu #(.XLEN(64), .AW(32)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .MemRead(MemRead64), .MemWrite(MemWrite64), .MemOp(MemOp64), .addr(addr64), .wdata(wdata64),
        .out_valid(out_valid64), .ReadData(ReadData64), .err(err64),
        .bus_req(bus_req64), .bus_wen(bus_wen64), .bus_addr(bus_addr64), .bus_wdata(bus_wdata64),
        .bus_wmask(bus_wmask64), .bus_gnt(bus_gnt64), .bus_rvalid(bus_rvalid64), .bus_rdata(bus_rdata64)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: accept interval, grant/rvalid intervals, completion interval, expected data.
    int          acc = -1, gcyc = -1, rcyc = -1, done = -1;
    bit          m_ld = 1'b0, m_err = 1'b0, chk_en = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wd = 32'h0;
    logic [3:0]  m_mask = 4'h0;
    logic [31:0] prev_rd = 32'h0, cur_rd = 32'h0;
    bit          prev_err = 1'b0, cur_err = 1'b0;
    int          req_cnt = 0, last_ov_cyc = -1;
    bit          req_unstable = 1'b0;
    logic [31:0] seen_addr = 32'h0, seen_wdata = 32'h0;
    logic [3:0]  seen_wmask = 4'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_is_err(input bit ld, input logic [2:0] op, input logic [31:0] a);
        bit legal;
        int sz;
        legal = ld ? (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (op <= 3'd2);
        sz = 1 << op[1:0];
        return !legal || ((int'(a[3:0]) % sz) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] raw, input logic [2:0] op, input int off);
        logic [63:0] v, keepm;
        int bits;
        bits  = 8 * (1 << op[1:0]);
        v     = 64'(raw) >> (8 * off);
        keepm = (64'd1 << bits) - 64'd1;
        v     = v & keepm;
        if (!op[2] && v[bits-1]) v = v | ~keepm;
        return v[31:0];
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit busy, req_e;
        if (chk_en) begin
            busy  = (cyc > acc) && (cyc <= done);
            req_e = !m_err && (cyc > acc) && (cyc <= gcyc);
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, cyc == done);
            chk("ReadData", ReadData, (cyc >= done) ? cur_rd : prev_rd);
            chk("err", err, (cyc >= done) ? cur_err : prev_err);
            chk("bus_req", bus_req, req_e);
            if (req_e) begin
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_wen", bus_wen, !m_ld);
                if (!m_ld) begin
                    chk("bus_wmask", bus_wmask, m_mask);
                    chk("bus_wdata", bus_wdata, m_wd);
                end
            end
            if (bus_req) begin
                if (req_cnt > 0 && (bus_addr != seen_addr || bus_wmask != seen_wmask ||
                                    bus_wdata != seen_wdata)) req_unstable = 1'b1;
                seen_addr  = bus_addr;
                seen_wmask = bus_wmask;
                seen_wdata = bus_wdata;
                req_cnt++;
            end
            if (out_valid) last_ov_cyc = cyc;
        end
    end

    task automatic noise_bus();
        bus_gnt    = (cyc == gcyc) ? 1'b1 : ((cyc > acc && cyc <= gcyc) ? 1'b0 : 1'($urandom));
        bus_rvalid = (cyc == rcyc) ? 1'b1 :
                     ((rcyc >= 0 && cyc > gcyc && cyc <= rcyc) ? 1'b0 : 1'($urandom));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom);
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            addr     = $urandom;
            noise_bus();
        end
    endtask

    task automatic do_txn(input bit rd, input bit wr, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int gd, input int rvd);
        int off, sz;
        logic [7:0] mm;
        off = int'(a[1:0]);
        sz  = 1 << op[1:0];
        @(posedge clk); #1;
        m_ld   = rd;
        m_err  = m_is_err(rd, op, a);
        m_addr = a & 32'hFFFF_FFFC;
        mm     = 8'((1 << sz) - 1) << off;
        m_mask = mm[3:0];
        m_wd   = wd << (8 * off);
        acc    = cyc;
        if (m_err) begin
            gcyc = -1; rcyc = -1; done = acc + 1;
        end else begin
            gcyc = acc + 1 + gd;
            rcyc = rd ? gcyc + 1 + rvd : -1;
            done = rd ? rcyc + 1 : gcyc + 1;
        end
        prev_rd  = cur_rd;
        prev_err = cur_err;
        cur_err  = m_err;
        cur_rd   = (rd && !m_err) ? m_load(rdat, op, off) : 32'h0;
        req_cnt = 0;
        req_unstable = 1'b0;
        in_valid = 1'b1; MemRead = rd; MemWrite = wr; MemOp = op; addr = a; wdata = wd;
        bus_rdata = rdat;
        noise_bus();
        while (cyc < done) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom);
            MemRead  = 1'($urandom);
            MemWrite = 1'($urandom);
            addr     = $urandom;
            noise_bus();
        end
    endtask

    task automatic t64(input logic [2:0] op, input logic [31:0] a, input logic [63:0] rdat,
                       input logic [63:0] exp);
        @(posedge clk); #1;
        in_valid64 = 1'b1; MemRead64 = 1'b1; MemOp64 = op; addr64 = a;
        @(posedge clk); #1;
        in_valid64 = 1'b0; bus_gnt64 = 1'b1;
        @(negedge clk);
        chk("x64_bus_req", bus_req64, 1'b1);
        chk("x64_bus_addr", bus_addr64, a & 32'hFFFF_FFF8);
        @(posedge clk); #1;
        bus_gnt64 = 1'b0; bus_rvalid64 = 1'b1; bus_rdata64 = rdat;
        @(posedge clk); #1;
        bus_rvalid64 = 1'b0;
        @(negedge clk);
        chk("x64_out_valid", out_valid64, 1'b1);
        chk("x64_ReadData", ReadData64, exp);
        chk("x64_err", err64, 1'b0);
    endtask

    initial begin
        bit rd, wr;
        logic [2:0] op;
        logic [31:0] a;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_bus_wmask", bus_wmask, 4'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        do_txn(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0);
        @(negedge clk); #1;
        chk("sw_addr", seen_addr, 32'h8000_0004);
        chk("sw_wmask", seen_wmask, 4'hF);
        chk("sw_wdata", seen_wdata, 32'hDEAD_BEEF);
        chk("sw_latency", last_ov_cyc - acc, 2);
        chk("sw_err", err, 1'b0);

        do_txn(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0);
        @(negedge clk); #1;
        chk("sb_wmask", seen_wmask, 4'h8);
        chk("sb_wdata", seen_wdata, 32'hA500_0000);
        chk("sb_addr", seen_addr, 32'h8000_0000);

        do_txn(1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0, 32'h12F4_5678, 0, 0);
        @(negedge clk); #1;
        chk("lb_data", ReadData, 32'hFFFF_FFF4);
        chk("lb_latency", last_ov_cyc - acc, 3);
        do_txn(1'b1, 1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h12F4_5678, 0, 0);
        @(negedge clk); #1;
        chk("lbu_data", ReadData, 32'h0000_00F4);
        do_txn(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h12F4_5678, 1, 2);
        @(negedge clk); #1;
        chk("lh_data", ReadData, 32'h0000_12F4);
        do_txn(1'b1, 1'b1, 3'b100, 32'h8000_0001, 32'h0, 32'h12F4_5678, 0, 0);
        @(negedge clk); #1;
        chk("both_high_load", ReadData, 32'h0000_0056);

        do_txn(1'b1, 1'b0, 3'b010, 32'h8000_0006, 32'h0, 32'h0, 0, 0);
        @(negedge clk); #1;
        chk("lw_mis_err", err, 1'b1);
        chk("lw_mis_latency", last_ov_cyc - acc, 1);
        chk("lw_mis_no_req", req_cnt, 0);
        do_txn(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        @(negedge clk); #1;
        chk("ld32_err", err, 1'b1);
        chk("ld32_data", ReadData, 32'h0);

        do_txn(1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h1122_3344, 32'h0, 3, 0);
        @(negedge clk); #1;
        chk("gnt_wait_req_cycles", req_cnt, 4);
        chk("gnt_wait_stable", req_unstable, 1'b0);
        chk("gnt_wait_latency", last_ov_cyc - acc, 5);

        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            op = 3'($urandom_range(0, 7));
            a  = 32'h8000_0000 | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) a = a & ~32'((1 << op[1:0]) - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            do_txn(rd, wr, op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        idle(2);

        // Reset while a load sits in WAIT; the late rvalid must be ignored.
        @(posedge clk); #1;
        m_ld = 1'b1; m_err = 1'b0; m_addr = 32'h8000_0010;
        acc = cyc; gcyc = acc + 1; rcyc = -1; done = acc + 1000;
        prev_rd = cur_rd; prev_err = cur_err;
        in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemOp = 3'b010; addr = 32'h8000_0010;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; acc = -1; gcyc = -1; done = -1;
        prev_rd = 32'h0; cur_rd = 32'h0; prev_err = 1'b0; cur_err = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_wait_in_ready", in_ready, 1'b1);
        chk("rst_wait_out_valid", out_valid, 1'b0);
        chk("rst_wait_bus_addr", bus_addr, 32'h0);
        chk("rst_wait_ReadData", ReadData, 32'h0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        idle(3);

        t64(3'b011, 32'h8000_0008, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
        t64(3'b010, 32'h8000_0004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        t64(3'b110, 32'h8000_0004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
